// File: rtl/deadlock_report_ctrl_if.sv
// Bundle between the deadlock detect units and the central report controller.
// The controller attaches through the slave modport; the units (or a bench) use master.
interface deadlock_report_ctrl_if #(
  parameter int unsigned PROC_NUM = 3,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned CNT_W    = 16
);
  logic [PROC_NUM-1:0] dl_in_vec;
  logic                all_finish;
  logic [CNT_W-1:0]    trans_in_cnt_0;
  logic [CNT_W-1:0]    trans_out_cnt_0;
  logic                dl_detect_out;
  logic [PROC_NUM-1:0] origin;
  logic                token_clear;
  logic                report_valid;
  logic [IDX_W-1:0]    report_proc;
  logic [CNT_W-1:0]    report_pending;

  modport slave (
    input  dl_in_vec, all_finish, trans_in_cnt_0, trans_out_cnt_0,
    output dl_detect_out, origin, token_clear, report_valid, report_proc, report_pending
  );

  modport master (
    output dl_in_vec, all_finish, trans_in_cnt_0, trans_out_cnt_0,
    input  dl_detect_out, origin, token_clear, report_valid, report_proc, report_pending
  );
endinterface

// File: rtl/deadlock_report_ctrl.sv
// Picks the lowest-index flagged process as trace origin, confirms the cycle after
// CONFIRM_CYC consecutive flagged cycles, and emits a one-shot report with the backlog.
module deadlock_report_ctrl #(
  parameter int unsigned PROC_NUM    = 3,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned CONFIRM_CYC = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  deadlock_report_ctrl_if.slave  bus
);

  localparam logic [7:0] ConfirmCnt = 8'(CONFIRM_CYC);

  typedef enum logic [1:0] {StIdle, StArm, StClear, StDetected} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [PROC_NUM-1:0] origin_q, origin_d;
  logic [IDX_W-1:0]    proc_q, proc_d;
  logic                detect_q, detect_d;
  logic                tclr_q, tclr_d;
  logic                rvalid_q, rvalid_d;
  logic [CNT_W-1:0]    pending_q, pending_d;

  logic [PROC_NUM-1:0] first_oh;
  logic [IDX_W-1:0]    first_idx;
  logic                sel_hit;

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    first_oh  = '0;
    first_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (bus.dl_in_vec[i]) begin
        first_oh    = '0;
        first_oh[i] = 1'b1;
        first_idx   = IDX_W'(i);
      end
    end
  end

  // origin_q is one-hot on the traced process while armed.
  assign sel_hit = |(bus.dl_in_vec & origin_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    origin_d  = origin_q;
    proc_d    = proc_q;
    detect_d  = detect_q;
    tclr_d    = 1'b0;
    rvalid_d  = 1'b0;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if ((|bus.dl_in_vec) && !bus.all_finish) begin
          state_d  = StArm;
          origin_d = first_oh;
          proc_d   = first_idx;
          cnt_d    = '0;
        end
      end
      StArm: begin
        // Abort wins over a confirm landing in the same cycle.
        if (!sel_hit || bus.all_finish) begin
          state_d  = StClear;
          origin_d = '0;
          tclr_d   = 1'b1;
        end else begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (cnt_d == ConfirmCnt) begin
            state_d   = StDetected;
            detect_d  = 1'b1;
            rvalid_d  = 1'b1;
            pending_d = bus.trans_in_cnt_0 - bus.trans_out_cnt_0;
          end
        end
      end
      StClear:    state_d = StIdle;
      StDetected: state_d = StDetected;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      origin_q  <= '0;
      proc_q    <= '0;
      detect_q  <= 1'b0;
      tclr_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      origin_q  <= origin_d;
      proc_q    <= proc_d;
      detect_q  <= detect_d;
      tclr_q    <= tclr_d;
      rvalid_q  <= rvalid_d;
      pending_q <= pending_d;
    end
  end

  assign bus.dl_detect_out  = detect_q;
  assign bus.origin         = origin_q;
  assign bus.token_clear    = tclr_q;
  assign bus.report_valid   = rvalid_q;
  assign bus.report_proc    = proc_q;
  assign bus.report_pending = pending_q;

endmodule

// File: tb/tb_deadlock_report_ctrl.sv
// Directed bench for deadlock_report_ctrl: reset, confirm, abort, all_finish,
// backlog wrap and asynchronous reset during a trace.
module tb_deadlock_report_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  deadlock_report_ctrl_if bus_if ();

  deadlock_report_ctrl dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.dl_in_vec       = '0;
    bus_if.all_finish      = 1'b0;
    bus_if.trans_in_cnt_0  = '0;
    bus_if.trans_out_cnt_0 = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_origin"}, 32'(bus_if.origin), 0);
    chk({tag, "_detect"}, 32'(bus_if.dl_detect_out), 0);
    chk({tag, "_tclr"}, 32'(bus_if.token_clear), 0);
    chk({tag, "_rvalid"}, 32'(bus_if.report_valid), 0);
    chk({tag, "_rproc"}, 32'(bus_if.report_proc), 0);
    chk({tag, "_pending"}, 32'(bus_if.report_pending), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset hold with all flags up.
    rst_n = 1'b0;
    bus_if.dl_in_vec       = 3'b111;
    bus_if.all_finish      = 1'b0;
    bus_if.trans_in_cnt_0  = '0;
    bus_if.trans_out_cnt_0 = '0;
    #2;
    chk_all_zero("rst_hold");
    step();
    step();
    chk_all_zero("rst_hold2");
    rst_n = 1'b1;
    step();
    chk("rst_rel_origin", 32'(bus_if.origin), 32'h1);
    chk("rst_rel_proc", 32'(bus_if.report_proc), 0);

    // Confirm on process 1 with a small backlog.
    do_reset();
    bus_if.dl_in_vec       = 3'b110;
    bus_if.trans_in_cnt_0  = 16'd10;
    bus_if.trans_out_cnt_0 = 16'd3;
    step();
    chk("cf_c1_origin", 32'(bus_if.origin), 32'h2);
    step();
    step();
    step();
    chk("cf_c4_detect", 32'(bus_if.dl_detect_out), 0);
    chk("cf_c4_rvalid", 32'(bus_if.report_valid), 0);
    step();
    chk("cf_c5_detect", 32'(bus_if.dl_detect_out), 1);
    chk("cf_c5_rvalid", 32'(bus_if.report_valid), 1);
    chk("cf_c5_proc", 32'(bus_if.report_proc), 1);
    chk("cf_c5_pending", 32'(bus_if.report_pending), 7);
    chk("cf_c5_origin", 32'(bus_if.origin), 32'h2);
    bus_if.all_finish = 1'b1;
    bus_if.dl_in_vec  = 3'b000;
    step();
    chk("cf_c6_rvalid", 32'(bus_if.report_valid), 0);
    chk("cf_c6_detect", 32'(bus_if.dl_detect_out), 1);
    step();
    step();
    chk("cf_sticky_detect", 32'(bus_if.dl_detect_out), 1);
    chk("cf_sticky_origin", 32'(bus_if.origin), 32'h2);
    chk("cf_sticky_tclr", 32'(bus_if.token_clear), 0);

    // Abort: flag drops in ARM cycle 3, then re-arm right after CLEAR.
    do_reset();
    bus_if.dl_in_vec = 3'b001;
    step();
    chk("ab_c1_origin", 32'(bus_if.origin), 32'h1);
    step();
    step();
    bus_if.dl_in_vec = 3'b000;
    step();
    chk("ab_c4_tclr", 32'(bus_if.token_clear), 1);
    chk("ab_c4_origin", 32'(bus_if.origin), 0);
    bus_if.dl_in_vec = 3'b001;
    step();
    chk("ab_c5_tclr", 32'(bus_if.token_clear), 0);
    chk("ab_c5_origin", 32'(bus_if.origin), 0);
    step();
    chk("ab_c6_rearm", 32'(bus_if.origin), 32'h1);
    chk("ab_c6_detect", 32'(bus_if.dl_detect_out), 0);
    bus_if.dl_in_vec = 3'b000;
    step();
    chk("ab_c7_tclr", 32'(bus_if.token_clear), 1);
    chk("ab_c7_detect", 32'(bus_if.dl_detect_out), 0);

    // all_finish suppresses arming for 20 cycles.
    do_reset();
    bus_if.all_finish = 1'b1;
    bus_if.dl_in_vec  = 3'b111;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("af_hold_origin", 32'(bus_if.origin), 0);
      chk("af_hold_tclr", 32'(bus_if.token_clear), 0);
    end
    bus_if.all_finish = 1'b0;
    step();
    chk("af_arm_origin", 32'(bus_if.origin), 32'h1);
    bus_if.all_finish = 1'b1;
    step();
    chk("af_mid_tclr", 32'(bus_if.token_clear), 1);
    chk("af_mid_origin", 32'(bus_if.origin), 0);

    // all_finish in the would-be confirming cycle aborts instead.
    do_reset();
    bus_if.dl_in_vec = 3'b100;
    step();
    step();
    step();
    step();
    bus_if.all_finish = 1'b1;
    step();
    chk("prio_tclr", 32'(bus_if.token_clear), 1);
    chk("prio_detect", 32'(bus_if.dl_detect_out), 0);
    chk("prio_rvalid", 32'(bus_if.report_valid), 0);

    // Backlog wrap, sampled in the last ARM cycle only.
    do_reset();
    bus_if.dl_in_vec       = 3'b010;
    bus_if.trans_in_cnt_0  = 16'd5;
    bus_if.trans_out_cnt_0 = 16'd1;
    step();
    step();
    step();
    step();
    bus_if.trans_in_cnt_0  = 16'h0002;
    bus_if.trans_out_cnt_0 = 16'hFFFF;
    step();
    chk("wrap_rvalid", 32'(bus_if.report_valid), 1);
    chk("wrap_pending", 32'(bus_if.report_pending), 32'h0003);
    bus_if.trans_in_cnt_0 = 16'h0100;
    step();
    chk("wrap_held", 32'(bus_if.report_pending), 32'h0003);

    // Asynchronous reset in ARM cycle 3, then a fresh trace.
    do_reset();
    bus_if.dl_in_vec = 3'b100;
    step();
    step();
    step();
    chk("ar_c3_origin", 32'(bus_if.origin), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_origin", 32'(bus_if.origin), 0);
    chk("ar_async_tclr", 32'(bus_if.token_clear), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_fresh_origin", 32'(bus_if.origin), 32'h4);
    chk("ar_fresh_tclr", 32'(bus_if.token_clear), 0);
    step();
    step();
    step();
    chk("ar_e4_detect", 32'(bus_if.dl_detect_out), 0);
    step();
    chk("ar_e5_detect", 32'(bus_if.dl_detect_out), 1);
    chk("ar_e5_rvalid", 32'(bus_if.report_valid), 1);
    chk("ar_e5_proc", 32'(bus_if.report_proc), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
